// File: rtl/fetcher_if.sv
// Fetch-stage bus: icache request/response, branch predictor lookup,
// decoder-side instruction queue head, and ROB redirect.
interface fetcher_if #(
   parameter int XLEN = 32
);
   // icache
   logic            fet_icache_req;
   logic [XLEN-1:0] fet_icache_addr;
   logic            icache_fet_ready;
   logic [XLEN-1:0] icache_fet_inst;
   // branch predictor
   logic [XLEN-1:0] fet_pc;
   logic            bp_pred;
   // decoder
   logic            dec_fet_pop;
   logic            fet_dec_valid;
   logic [XLEN-1:0] fet_dec_inst;
   logic [XLEN-1:0] fet_dec_pc;
   logic            fet_dec_pred_jump;
   // ROB redirect
   logic            rob_flush;
   logic [XLEN-1:0] rob_flush_pc;

   // Fetch stage side
   modport master (
      output fet_icache_req, fet_icache_addr, fet_pc,
      output fet_dec_valid, fet_dec_inst, fet_dec_pc, fet_dec_pred_jump,
      input  icache_fet_ready, icache_fet_inst, bp_pred,
      input  dec_fet_pop, rob_flush, rob_flush_pc
   );

   // Environment side (icache, predictor, decoder, ROB)
   modport slave (
      input  fet_icache_req, fet_icache_addr, fet_pc,
      input  fet_dec_valid, fet_dec_inst, fet_dec_pc, fet_dec_pred_jump,
      output icache_fet_ready, icache_fet_inst, bp_pred,
      output dec_fet_pop, rob_flush, rob_flush_pc
   );
endinterface

// File: rtl/fetcher.sv
// Fetch stage: one outstanding icache request at a time, minimal decode of
// JAL / conditional branches to form the next PC, and a circular
// instruction queue drained by the decoder. A ROB flush redirects the PC
// and empties the queue; an in-flight icache response is then discarded.
module fetcher #(
   parameter int              XLEN     = 32,
   parameter int              IQ_DEPTH = 8,
   parameter int              IQ_WIDTH = 3,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic      clk,
   input  logic      rst,
   fetcher_if.master bus
);

   localparam logic [6:0]          OPC_JAL    = 7'b1101111;
   localparam logic [6:0]          OPC_BRANCH = 7'b1100011;
   localparam logic [IQ_WIDTH:0]   IQ_FULL    = (IQ_WIDTH+1)'(IQ_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

   state_t                state_q, state_d;
   logic [XLEN-1:0]       pc_q, pc_d;
   logic [IQ_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
   logic [IQ_WIDTH:0]     count_q, count_d;

   logic [XLEN-1:0]       iq_inst [IQ_DEPTH];
   logic [XLEN-1:0]       iq_pc   [IQ_DEPTH];
   logic                  iq_pred [IQ_DEPTH];

   logic                  push, pop, pred;
   logic [XLEN-1:0]       next_pc, imm_j, imm_b;
   logic [XLEN-1:0]       inst;

   assign inst  = bus.icache_fet_inst;
   assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

   // Next-PC and prediction bit from the returning instruction word
   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and a latch is never inferred.
   always_comb begin
      pred    = 1'b0;
      next_pc = pc_q + XLEN'(4);
      case (inst[6:0])
         OPC_JAL: begin
            pred    = 1'b1;
            next_pc = pc_q + imm_j;
         end
         OPC_BRANCH: begin
            pred = bus.bp_pred;
            if (bus.bp_pred) next_pc = pc_q + imm_b;
         end
         default: ;
      endcase
   end

   // Fetch FSM next state and queue push decision
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         S_IDLE:
            if (!bus.rob_flush && (count_q < IQ_FULL)) state_d = S_WAIT;
         S_WAIT:
            if (bus.icache_fet_ready) begin
               state_d = S_IDLE;
               push    = !bus.rob_flush;
            end else if (bus.rob_flush) begin
               state_d = S_DISCARD;
            end
         S_DISCARD:
            if (bus.icache_fet_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign pop = bus.dec_fet_pop && (count_q != '0) && !bus.rob_flush;

   // PC, queue pointers and occupancy; flush overrides push and pop
   always_comb begin
      pc_d    = pc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (bus.rob_flush) begin
         pc_d    = bus.rob_flush_pc;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            pc_d   = next_pc;
            tail_d = tail_q + 1'b1;
         end
         if (pop) head_d = head_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
         endcase
      end
   end

   // State, PC and queue control registers
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Queue storage write
   // NOTE: the storage array is not reset; entries are only observable
   // through the head while count is non-zero, and the outputs are gated.
   always_ff @(posedge clk) begin
      if (push) begin
         iq_inst[tail_q] <= inst;
         iq_pc[tail_q]   <= pc_q;
         iq_pred[tail_q] <= pred;
      end
   end

   assign bus.fet_pc            = pc_q;
   assign bus.fet_icache_addr   = pc_q;
   assign bus.fet_icache_req    = (state_q == S_WAIT);
   assign bus.fet_dec_valid     = (count_q != '0);
   assign bus.fet_dec_inst      = bus.fet_dec_valid ? iq_inst[head_q] : '0;
   assign bus.fet_dec_pc        = bus.fet_dec_valid ? iq_pc[head_q]   : '0;
   assign bus.fet_dec_pred_jump = bus.fet_dec_valid && iq_pred[head_q];

endmodule

// File: tb/tb_fetcher.sv
// Scoreboard bench for fetcher: directed test sequences push hand-computed
// queue entries; a monitor pops and compares them whenever the decoder
// side consumes the queue head. A behavioural icache answers requests
// after a programmable latency.
module tb_fetcher;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pred;
   } exp_t;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] JAL = 32'h0080006F;
   localparam logic [31:0] BEQ = 32'hFE000EE3;
   localparam logic [31:0] ADI = 32'h00100093;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetcher_if bus ();

   fetcher dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks    = 0;
   int   errors    = 0;
   int   pops_seen = 0;
   int   ic_lat    = 0;
   exp_t exp_q[$];
   logic [31:0] imem_ov [logic [31:0]];

   function automatic logic [31:0] imem(input logic [31:0] a);
      if (imem_ov.exists(a)) return imem_ov[a];
      return NOP;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Main-thread drive point: 2 ns after the falling edge
   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic push_exp(input logic [31:0] inst, input logic [31:0] pc, input logic pred);
      exp_t e;
      e.inst = inst;
      e.pc   = pc;
      e.pred = pred;
      exp_q.push_back(e);
   endtask

   // icache model: accepts a request, replies with a one-cycle pulse after ic_lat cycles
   initial begin : icache_model
      logic        pending;
      logic [31:0] req_addr;
      int          wait_cnt;
      pending  = 1'b0;
      req_addr = '0;
      wait_cnt = 0;
      bus.icache_fet_ready = 1'b0;
      bus.icache_fet_inst  = '0;
      forever begin
         @(negedge clk);
         #1;
         bus.icache_fet_ready = 1'b0;
         bus.icache_fet_inst  = '0;
         if (rst) begin
            pending = 1'b0;
         end else begin
            if (!pending && bus.fet_icache_req) begin
               pending  = 1'b1;
               req_addr = bus.fet_icache_addr;
               wait_cnt = ic_lat;
            end
            if (pending) begin
               if (wait_cnt == 0) begin
                  bus.icache_fet_ready = 1'b1;
                  bus.icache_fet_inst  = imem(req_addr);
                  pending = 1'b0;
               end else begin
                  wait_cnt--;
               end
            end
         end
      end
   end

   // Monitor: compares the head entry each cycle the decoder really pops it
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (!rst && bus.dec_fet_pop && bus.fet_dec_valid && !bus.rob_flush) begin
            pops_seen++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_entry: got inst %h pc %h pred %b, none expected",
                        bus.fet_dec_inst, bus.fet_dec_pc, bus.fet_dec_pred_jump);
            end else begin
               e = exp_q.pop_front();
               if (bus.fet_dec_inst !== e.inst || bus.fet_dec_pc !== e.pc ||
                   bus.fet_dec_pred_jump !== e.pred) begin
                  errors++;
                  $display("FAIL queue_entry: got inst %h pc %h pred %b expected inst %h pc %h pred %b",
                           bus.fet_dec_inst, bus.fet_dec_pc, bus.fet_dec_pred_jump,
                           e.inst, e.pc, e.pred);
               end
            end
         end
      end
   end

   // Wait until fetch stalls on a full queue, then check the stalled PC
   task automatic fill_check(input string name, input logic [31:0] next_pc);
      int low = 0;
      int n   = 0;
      while (low < 4 && n < 300) begin
         tick();
         n++;
         if (bus.fet_icache_req) low = 0;
         else low++;
      end
      check({name, "_fill_done"}, 32'(low >= 4), 32'd1);
      check({name, "_req_stalled"}, 32'(bus.fet_icache_req), 32'd0);
      check({name, "_fet_pc"}, bus.fet_pc, next_pc);
      check({name, "_icache_addr"}, bus.fet_icache_addr, next_pc);
      check({name, "_valid_full"}, 32'(bus.fet_dec_valid), 32'd1);
   endtask

   task automatic pop_n(input string name, input int n);
      int target = pops_seen + n;
      int k      = 0;
      bus.dec_fet_pop = 1'b1;
      while (pops_seen < target && k < 300) begin
         tick();
         k++;
      end
      bus.dec_fet_pop = 1'b0;
      check({name, "_pops"}, 32'(pops_seen - (target - n)), 32'(n));
   endtask

   task automatic do_flush(input string name, input logic [31:0] pc);
      bus.rob_flush    = 1'b1;
      bus.rob_flush_pc = pc;
      exp_q.delete();
      tick();
      bus.rob_flush = 1'b0;
      check({name, "_valid_after_flush"}, 32'(bus.fet_dec_valid), 32'd0);
      check({name, "_pc_after_flush"}, bus.fet_pc, pc);
   endtask

   task automatic wait_req(input string name, input logic [31:0] addr);
      int k = 0;
      while (!bus.fet_icache_req && k < 40) begin
         tick();
         k++;
      end
      check({name, "_req_seen"}, 32'(bus.fet_icache_req), 32'd1);
      check({name, "_req_addr"}, bus.fet_icache_addr, addr);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      bus.bp_pred      = 1'b0;
      bus.dec_fet_pop  = 1'b0;
      bus.rob_flush    = 1'b0;
      bus.rob_flush_pc = '0;
      imem_ov[32'h100] = JAL;
      imem_ov[32'h200] = BEQ;
      imem_ov[32'h300] = ADI;

      // Reset state
      tick();
      tick();
      check("rst_req", 32'(bus.fet_icache_req), 32'd0);
      check("rst_valid", 32'(bus.fet_dec_valid), 32'd0);
      check("rst_fet_pc", bus.fet_pc, 32'h0);
      check("rst_addr", bus.fet_icache_addr, 32'h0);
      check("rst_dec_inst", bus.fet_dec_inst, 32'h0);
      check("rst_dec_pc", bus.fet_dec_pc, 32'h0);
      check("rst_dec_pred", 32'(bus.fet_dec_pred_jump), 32'd0);

      // Sequential NOPs fill the queue from 0 and stall at pc 32
      for (int i = 0; i < 8; i++) push_exp(NOP, 32'(4 * i), 1'b0);
      rst = 1'b0;
      fill_check("nop_fill", 32'h20);
      pop_n("nop_fill", 8);

      // JAL +8 at 0x100
      do_flush("jal", 32'h100);
      push_exp(JAL, 32'h100, 1'b1);
      for (int i = 0; i < 7; i++) push_exp(NOP, 32'h108 + 32'(4 * i), 1'b0);
      fill_check("jal", 32'h124);
      pop_n("jal", 8);

      // BEQ -4 at 0x200 predicted taken: loops 0x200 <-> 0x1FC
      bus.bp_pred = 1'b1;
      do_flush("beq_t", 32'h200);
      for (int i = 0; i < 4; i++) begin
         push_exp(BEQ, 32'h200, 1'b1);
         push_exp(NOP, 32'h1FC, 1'b0);
      end
      fill_check("beq_t", 32'h200);
      pop_n("beq_t", 8);

      // Same branch predicted not taken: falls through
      bus.bp_pred = 1'b0;
      do_flush("beq_nt", 32'h200);
      push_exp(BEQ, 32'h200, 1'b0);
      for (int i = 0; i < 7; i++) push_exp(NOP, 32'h204 + 32'(4 * i), 1'b0);
      fill_check("beq_nt", 32'h220);
      pop_n("beq_nt", 8);

      // Flush while waiting on a 3-cycle icache response: response dropped
      ic_lat = 3;
      do_flush("pre_wait", 32'h300);
      wait_req("pre_wait", 32'h300);
      do_flush("wait_flush", 32'h400);
      check("discard_req_low", 32'(bus.fet_icache_req), 32'd0);
      for (int i = 0; i < 8; i++) push_exp(NOP, 32'h400 + 32'(4 * i), 1'b0);
      wait_req("after_discard", 32'h400);
      fill_check("after_discard", 32'h420);
      pop_n("after_discard", 8);

      // Flush coinciding with a response, push and pop all cancelled
      ic_lat = 0;
      do_flush("pre_same", 32'h600);
      for (int i = 0; i < 4; i++) tick();
      begin
         int k = 0;
         while (!(bus.icache_fet_ready && bus.fet_dec_valid) && k < 40) begin
            tick();
            k++;
         end
      end
      check("same_cycle_ready_valid", 32'(bus.icache_fet_ready && bus.fet_dec_valid), 32'd1);
      bus.dec_fet_pop = 1'b1;
      do_flush("same_cycle", 32'h80);
      bus.dec_fet_pop = 1'b0;
      for (int i = 0; i < 8; i++) push_exp(NOP, 32'h80 + 32'(4 * i), 1'b0);
      wait_req("same_cycle", 32'h80);
      fill_check("same_cycle", 32'hA0);

      // Continuous pops while fetching: pointers wrap several times
      for (int i = 8; i < 24; i++) push_exp(NOP, 32'h80 + 32'(4 * i), 1'b0);
      pop_n("wrap", 24);
      check("wrap_scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
